// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  localparam logic [6:0] SSEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex2sseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex2sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SSEG_HEX[nibble];

endmodule

// File: rtl/disp_arb_seven_seg.sv
// Round-robin arbiter sharing the 8-digit seven-segment display between two
// requesters, with minimum dwell time and a registered decode of the owner's value.
module disp_arb_seven_seg
  import sseg_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] val0,
  input  logic [31:0] val1,
  input  logic [7:0]  mask0,
  input  logic [7:0]  mask1,
  input  logic        lzb0,
  input  logic        lzb1,
  output logic [1:0]  ack,
  output logic [1:0]  gnt,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4,
  output logic [6:0]  seg5,
  output logic [6:0]  seg6,
  output logic [6:0]  seg7,
  output logic [7:0]  seg_dis
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] CNT_MAX = DW_W'(DWELL - 1);

  arb_state_t      state, state_nxt;
  logic            owner, owner_nxt;
  logic            rr, rr_nxt;
  logic [DW_W-1:0] cnt, cnt_nxt;
  logic            grant;
  logic [1:0]      ack_nxt;

  logic [31:0]     sel_val;
  logic [7:0]      sel_mask;
  logic            sel_lzb;
  logic [7:0]      lz;
  logic            zero_run;
  logic [6:0]      dec_seg [8];
  logic [6:0]      seg_q   [8];
  logic [7:0]      dis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
      cnt   <= '0;
      ack   <= 2'b00;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr    <= rr_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
    end
  end

  // A handover (release or preemption) goes straight to the other owner, never via IDLE.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant     = 1'b1;
          state_nxt = OWN;
          if (&req) begin
            owner_nxt = rr;
            rr_nxt    = ~rr;
          end else begin
            owner_nxt = req[1];
          end
        end
      end
      OWN: begin
        if (!req[owner]) begin
          if (req[~owner]) begin
            grant     = 1'b1;
            owner_nxt = ~owner;
          end else begin
            state_nxt = IDLE;
          end
        end else if (req[~owner] && cnt == CNT_MAX) begin
          grant     = 1'b1;
          owner_nxt = ~owner;
        end else if (cnt < CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) cnt_nxt = '0;
    ack_nxt = grant ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
  end

  assign gnt = (state == OWN) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  // Display follows the incoming owner so new digits land together with gnt.
  assign sel_val  = owner_nxt ? val1  : val0;
  assign sel_mask = owner_nxt ? mask1 : mask0;
  assign sel_lzb  = owner_nxt ? lzb1  : lzb0;

  always_comb begin
    lz       = '0;
    zero_run = sel_lzb;
    for (int k = 7; k >= 1; k--) begin
      zero_run = zero_run & (sel_val[4*k +: 4] == 4'h0);
      lz[k]    = zero_run;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_dec
    hex2sseg u_hex (
      .nibble (sel_val[4*k +: 4]),
      .seg    (dec_seg[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || state_nxt == IDLE) begin
      for (int k = 0; k < 8; k++) seg_q[k] <= SSEG_BLANK;
      dis_q <= 8'hFF;
    end else begin
      for (int k = 0; k < 8; k++) seg_q[k] <= dec_seg[k];
      dis_q <= sel_mask | lz;
    end
  end

  assign seg0    = seg_q[0];
  assign seg1    = seg_q[1];
  assign seg2    = seg_q[2];
  assign seg3    = seg_q[3];
  assign seg4    = seg_q[4];
  assign seg5    = seg_q[5];
  assign seg6    = seg_q[6];
  assign seg7    = seg_q[7];
  assign seg_dis = dis_q;

endmodule

// File: tb/tb_disp_arb_seven_seg.sv
// Bench for disp_arb_seven_seg: behavioural arbiter/display model checked every
// cycle, plus directed literal expectations from the hand-worked scenarios.
module tb_disp_arb_seven_seg;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] val0, val1;
  logic [7:0]  mask0, mask1;
  logic        lzb0, lzb1;
  logic [1:0]  ack, gnt;
  logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [7:0]  seg_dis;

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  disp_arb_seven_seg #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .val0    (val0),
    .val1    (val1),
    .mask0   (mask0),
    .mask1   (mask1),
    .lzb0    (lzb0),
    .lzb1    (lzb1),
    .ack     (ack),
    .gnt     (gnt),
    .seg0    (seg0),
    .seg1    (seg1),
    .seg2    (seg2),
    .seg3    (seg3),
    .seg4    (seg4),
    .seg5    (seg5),
    .seg6    (seg6),
    .seg7    (seg7),
    .seg_dis (seg_dis)
  );

  always #5 clk = ~clk;

  logic [63:0] disp_act;
  assign disp_act = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0, seg_dis};

  int          m_own = -1;
  int          m_cnt = 0;
  int          m_rr  = 0;
  logic [1:0]  m_ack = 2'b00;
  logic [63:0] m_disp;
  bit          m_valid = 1'b0;
  int          m_next;
  bit          m_grant;

  // Display image for an owner: {seg7..seg0, seg_dis}; -1 means idle.
  function automatic logic [63:0] expectDisp(int own);
    logic [31:0] v;
    logic [7:0]  m;
    logic        z;
    logic [63:0] r;
    if (own < 0) return {{8{7'h7F}}, 8'hFF};
    v = (own == 1) ? val1 : val0;
    m = (own == 1) ? mask1 : mask0;
    z = (own == 1) ? lzb1 : lzb0;
    for (int k = 0; k < 8; k++) begin
      r[8 + 7*k +: 7] = hex_tab[v[4*k +: 4]];
      r[k] = m[k] | (z && k > 0 && ((v >> (4*k)) == 32'd0));
    end
    return r;
  endfunction

  function automatic logic [1:0] ownerToGnt(int own);
    return (own < 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_own = -1; m_cnt = 0; m_rr = 0; m_ack = 2'b00; m_valid = 1'b1;
    end else begin
      m_next  = m_own;
      m_grant = 1'b0;
      if (m_own < 0) begin
        if (req == 2'b11) begin
          m_next = m_rr; m_rr = 1 - m_rr; m_grant = 1'b1;
        end else if (req != 2'b00) begin
          m_next = req[1] ? 1 : 0; m_grant = 1'b1;
        end
      end else if (!req[m_own]) begin
        if (req[1-m_own]) begin
          m_next = 1 - m_own; m_grant = 1'b1;
        end else begin
          m_next = -1;
        end
      end else if (req[1-m_own] && m_cnt == DWELL - 1) begin
        m_next = 1 - m_own; m_grant = 1'b1;
      end else if (m_cnt < DWELL - 1) begin
        m_cnt++;
      end
      if (m_grant) m_cnt = 0;
      m_ack = m_grant ? ownerToGnt(m_next) : 2'b00;
      m_own = m_next;
    end
    m_disp = expectDisp(m_own);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_gnt", 64'(gnt), 64'(ownerToGnt(m_own)));
      checkOutput("model_ack", 64'(ack), 64'(m_ack));
      checkOutput("model_disp", disp_act, m_disp);
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input int n);
    req = r;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] lz_vals [5] = '{32'h0000_0000, 32'h0010_0000, 32'hF000_0000, 32'h0000_0001, 32'h0300_0040};

  initial begin
    reset = 1'b1; req = 2'b00;
    val0 = '0; val1 = '0; mask0 = '0; mask1 = '0; lzb0 = 1'b0; lzb1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", 64'(gnt), 64'h0);
    checkOutput("rst_ack", 64'(ack), 64'h0);
    checkOutput("rst_dis", 64'(seg_dis), 64'hFF);
    checkOutput("rst_seg0", 64'(seg0), 64'h7F);
    checkOutput("rst_seg7", 64'(seg7), 64'h7F);

    reset = 1'b0;
    val0 = 32'h0000_00A5; lzb0 = 1'b1;
    applyStimulus(2'b01, 1);
    checkOutput("a5_gnt", 64'(gnt), 64'h1);
    checkOutput("a5_ack", 64'(ack), 64'h1);
    applyStimulus(2'b01, 1);
    checkOutput("a5_ack_drop", 64'(ack), 64'h0);
    checkOutput("a5_seg0", 64'(seg0), 64'h12);
    checkOutput("a5_seg1", 64'(seg1), 64'h08);
    checkOutput("a5_dis", 64'(seg_dis), 64'hFC);
    checkOutput("model_pin_dis", 64'(m_disp[7:0]), 64'hFC);
    applyStimulus(2'b00, 1);
    checkOutput("idle_dis", 64'(seg_dis), 64'hFF);

    val1 = 32'h1234_5678;
    applyStimulus(2'b11, 1);
    checkOutput("both_gnt", 64'(gnt), 64'h1);
    applyStimulus(2'b11, 3);
    checkOutput("dwell_hold", 64'(gnt), 64'h1);
    applyStimulus(2'b11, 1);
    checkOutput("preempt_gnt", 64'(gnt), 64'h2);
    checkOutput("preempt_ack", 64'(ack), 64'h2);
    checkOutput("preempt_seg0", 64'(seg0), 64'h00);
    checkOutput("preempt_dis", 64'(seg_dis), 64'h00);
    applyStimulus(2'b11, 3);
    checkOutput("dwell_hold1", 64'(gnt), 64'h2);
    applyStimulus(2'b11, 1);
    checkOutput("back_gnt", 64'(gnt), 64'h1);
    checkOutput("back_ack", 64'(ack), 64'h1);

    applyStimulus(2'b11, 1);
    applyStimulus(2'b10, 1);
    checkOutput("release_gnt", 64'(gnt), 64'h2);
    checkOutput("release_ack", 64'(ack), 64'h2);
    applyStimulus(2'b00, 1);
    checkOutput("release_idle", 64'(gnt), 64'h0);

    val0 = 32'h0; lzb0 = 1'b1; mask0 = 8'h00;
    applyStimulus(2'b01, 1);
    checkOutput("zero_dis", 64'(seg_dis), 64'hFE);
    checkOutput("zero_seg0", 64'(seg0), 64'h40);
    mask0 = 8'h01;
    applyStimulus(2'b01, 1);
    checkOutput("zero_mask_dis", 64'(seg_dis), 64'hFF);
    mask0 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      val0 = lz_vals[i];
      applyStimulus(2'b01, 1);
    end
    val0 = 32'h0010_0000;
    applyStimulus(2'b01, 1);
    checkOutput("lz_mid_dis", 64'(seg_dis), 64'hC0);

    applyStimulus(2'b10, 1);
    checkOutput("pre_rst_gnt", 64'(gnt), 64'h2);
    reset = 1'b1;
    applyStimulus(2'b10, 1);
    checkOutput("midrst_gnt", 64'(gnt), 64'h0);
    checkOutput("midrst_ack", 64'(ack), 64'h0);
    checkOutput("midrst_dis", 64'(seg_dis), 64'hFF);
    reset = 1'b0;
    applyStimulus(2'b11, 1);
    checkOutput("rr_reset_gnt", 64'(gnt), 64'h1);
    checkOutput("rr_reset_ack", 64'(ack), 64'h1);

    applyStimulus(2'b00, 2);
    applyStimulus(2'b10, 1);
    checkOutput("pulse_gnt", 64'(gnt), 64'h2);
    checkOutput("pulse_ack", 64'(ack), 64'h2);
    applyStimulus(2'b00, 1);
    checkOutput("pulse_release", 64'(gnt), 64'h0);
    applyStimulus(2'b00, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
